wb_line_master: RTL and testbench
=================================

# wb_line_master

Pipelined Wishbone master that moves one whole cache line per request between the cache controller and the word-addressed Wishbone memory slave. A refill issues `LINE_WORDS` back-to-back read strobes and assembles the returned words into a line; a writeback issues `LINE_WORDS` write strobes from a supplied line. It sits directly upstream of the memory: its `wb_*_o` ports drive the slave's `wb_*_i` ports one-to-one.

## Interface
- `WB_AW`, 12, word address width of the bus.
- `WB_DW`, 32, data width; `WB_DW/8` byte lanes.
- `LINE_WORDS`, 4, words per line; power of two, at least 2.
- `TIMEOUT_CYCLES`, 1023, ack watchdog limit (see Configuration).
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  line request present.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = writeback, 0 = refill.
- `req_line_i`  in  `WB_AW-log2(LINE_WORDS)`  line address.
- `req_wdata_i`  in  `LINE_WORDS*WB_DW`  writeback line; word k in bits `[k*WB_DW +: WB_DW]`.
- `rd_line_o`  out  `LINE_WORDS*WB_DW`  refilled line, same packing.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  qualifies `done_o`: transfer aborted.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone cycle, strobe and write-enable.
- `wb_adr_o`  out  `WB_AW`  word address.
- `wb_dat_o`  out  `WB_DW`  write data.
- `wb_sel_o`  out  `WB_DW/8`  byte select; always all ones during a strobe.
- `wb_stall_i`, `wb_ack_i`, `wb_err_i`  in  1  slave stall, acknowledge and error.
- `wb_dat_i`  in  `WB_DW`  read data.

## Operation
- States: IDLE, BUS, DONE.
- IDLE: `req_ready_o`=1. On accept, latch `req_we_i`, `req_line_i` and `req_wdata_i`; clear the issue and ack counters; go to BUS.
- BUS: `wb_cyc_o`=1. `wb_stb_o`=1 while issue count < `LINE_WORDS`.
  - `wb_adr_o` = {line, issue count}; `wb_dat_o` = latched word[issue count].
  - Issue count increments on a cycle with `wb_stb_o && !wb_stall_i`.
- Acks: each `wb_ack_i` while ack count < issue count writes `wb_dat_i` into `rd_line_o` word[ack count] (reads only) and increments ack count. Acks with nothing outstanding are ignored.
- BUS→DONE when ack count reaches `LINE_WORDS`, or on `wb_err_i` (abort: drop cyc/stb at once, `err_o`=1).
- DONE: `done_o`=1 for one cycle, `err_o` valid with it; go to IDLE.
- `rd_line_o` holds its value until the next refill writes it; on error, unreceived words keep their old contents.
- Writebacks never modify `rd_line_o`.
- Counters are `log2(LINE_WORDS)+1` bits wide and never wrap within a transfer.

## Timing
- Reset values: `req_ready_o`=0 while `rst_i` is high and 1 after release; all other outputs 0, including `rd_line_o`.
- Accept at edge E0 with a zero-stall, ack-next-cycle slave:
  - strobes in cycles 1..`LINE_WORDS`;
  - acks in cycles 2..`LINE_WORDS+1`;
  - `wb_cyc_o` drops and `done_o` pulses in cycle `LINE_WORDS+2`.
  - Latency is `LINE_WORDS+2` cycles, 6 at default.
- Stall cycles add one cycle each. Address and data hold stable while `wb_stall_i`=1.
- The earliest next request is accepted in the cycle after `done_o`.
- Ack and strobe in the same cycle are both counted.
- `wb_err_i` in the same cycle as the last ack: error wins and `err_o`=1.
- Reset asserted mid-transfer: `wb_cyc_o`/`wb_stb_o` drop immediately (asynchronously), state returns to IDLE, and no `done_o` is produced.

## Configuration
- `WB_LINE_TIMEOUT_EN` defined:
  - In BUS, a watchdog counts consecutive cycles with acks outstanding or stb stalled and no `wb_ack_i`; any ack clears it.
  - On reaching `TIMEOUT_CYCLES`, abort exactly as for `wb_err_i`: DONE with `err_o`=1.
- Not defined: no watchdog logic; the block waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Test plan
- Refill of line 0x005 from a zero-stall slave preloaded with word k = 0xA000_0000+k → `wb_adr_o` 0x014..0x017 in consecutive cycles; `rd_line_o` = {0xA000_0003, 0xA000_0002, 0xA000_0001, 0xA000_0000}; `done_o` 6 cycles after accept; `err_o`=0.
- Writeback of line 0x3FF with words 0x1111_1111..0x4444_4444 followed by a refill of the same line → memory words 0xFFC..0xFFF match and the refill returns the identical line; `wb_sel_o`=4'hF on every strobe.
- Refill with `wb_stall_i` high for 3 cycles on the second strobe → address holds at word 1 for those cycles, exactly 4 strobes accepted, latency 9 cycles, data correct.
- `wb_err_i` on the second ack → cyc/stb drop in the next cycle, `done_o`=`err_o`=1, only word 0 of `rd_line_o` updated.
- `rst_i` asserted in the middle of BUS → `wb_cyc_o`=0 immediately, no `done_o`, and a subsequent refill completes normally.
- With `WB_LINE_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=8, the slave never acks → `done_o` with `err_o`=1 after 8 idle-ack cycles. Without the macro, no `done_o` within 100 cycles.

Source files
------------

// File: rtl/wb_line_master.sv
`default_nettype none
// =============================================================================
// wb_line_master : pipelined Wishbone master moving one cache line per request
//                  (refill = LINE_WORDS reads, writeback = LINE_WORDS writes).
//                  Optional ack watchdog: define WB_LINE_TIMEOUT_EN.
// Revision 1.0
// =============================================================================
module wb_line_master #(
  parameter int WB_AW          = 12,
  parameter int WB_DW          = 32,
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic                                   req_we_i,
  input  logic [WB_AW-$clog2(LINE_WORDS)-1:0]    req_line_i,
  input  logic [LINE_WORDS*WB_DW-1:0]            req_wdata_i,
  output logic [LINE_WORDS*WB_DW-1:0]            rd_line_o,
  output logic                                   done_o,
  output logic                                   err_o,
  output logic                                   wb_cyc_o,
  output logic                                   wb_stb_o,
  output logic                                   wb_we_o,
  output logic [WB_AW-1:0]                       wb_adr_o,
  output logic [WB_DW-1:0]                       wb_dat_o,
  output logic [WB_DW/8-1:0]                     wb_sel_o,
  input  logic                                   wb_stall_i,
  input  logic                                   wb_ack_i,
  input  logic                                   wb_err_i,
  input  logic [WB_DW-1:0]                       wb_dat_i
);

  localparam int IDX_W   = $clog2(LINE_WORDS);
  localparam int CNT_W   = IDX_W + 1;
  localparam int LINE_AW = WB_AW - IDX_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (LINE_WORDS < 2 || (1 << IDX_W) != LINE_WORDS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_line_master: LINE_WORDS must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic                          we_q;
  logic [LINE_AW-1:0]            line_q;
  logic [LINE_WORDS*WB_DW-1:0]   wdata_q;
  logic [CNT_W-1:0]              issue_cnt;
  logic [CNT_W-1:0]              ack_cnt;
  logic                          err_q;
  logic                          accept;
  logic                          in_bus;
  logic                          stb;
  logic                          issue_fire;
  logic                          ack_take;
  logic                          last_ack;
  logic                          timeout;
  logic                          abort;
  logic [IDX_W-1:0]              issue_idx;
  logic [IDX_W-1:0]              ack_idx;

  assign in_bus     = (state == BUS);
  assign req_ready_o = (state == IDLE) && !rst_i;
  assign accept     = req_valid_i && req_ready_o;
  assign issue_idx  = issue_cnt[IDX_W-1:0];
  assign ack_idx    = ack_cnt[IDX_W-1:0];
  assign stb        = in_bus && (issue_cnt < CNT_FULL);
  assign issue_fire = stb && !wb_stall_i;
  // Acks with nothing outstanding are ignored; an error in the same cycle wins.
  assign ack_take   = in_bus && wb_ack_i && (ack_cnt < issue_cnt);
  assign abort      = in_bus && (wb_err_i || timeout);
  assign last_ack   = ack_take && (ack_cnt == CNT_LAST);

  assign wb_cyc_o = in_bus;
  assign wb_stb_o = stb;
  assign wb_we_o  = in_bus && we_q;
  assign wb_adr_o = stb ? {line_q, issue_idx} : '0;
  assign wb_dat_o = (stb && we_q) ? wdata_q[WB_DW*int'(issue_idx) +: WB_DW] : '0;
  assign wb_sel_o = {(WB_DW/8){stb}};
  assign done_o   = (state == DONE);
  assign err_o    = done_o && err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUS;
      BUS:     if (abort || last_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      line_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      ack_cnt   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      we_q      <= req_we_i;
      line_q    <= req_line_i;
      wdata_q   <= req_wdata_i;
      issue_cnt <= '0;
      ack_cnt   <= '0;
      err_q     <= 1'b0;
    end else if (in_bus) begin
      if (issue_fire) begin
        issue_cnt <= issue_cnt + CNT_ONE;
      end
      if (ack_take && !abort) begin
        ack_cnt <= ack_cnt + CNT_ONE;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  // Refill words land in ack order; words never acked keep their old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_line_o <= '0;
    end else if (ack_take && !abort && !we_q) begin
      rd_line_o[WB_DW*int'(ack_idx) +: WB_DW] <= wb_dat_i;
    end
  end

`ifdef WB_LINE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_idle;

  // A cycle is idle while the slave owes us something and did not ack.
  assign wd_idle = in_bus && !wb_ack_i && ((ack_cnt < issue_cnt) || (stb && wb_stall_i));
  assign timeout = wd_idle && (wd_cnt == WD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (wd_idle && !timeout) begin
      wd_cnt <= wd_cnt + WD_ONE;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_line_master.sv
`default_nettype none
// tb_wb_line_master : randomized bench with a pipelined slave model, a line-level
// reference model and scoreboards for bus strobes and line completions.
module tb_wb_line_master;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int IW  = 2;
  localparam int LAW = AW - IW;
  localparam int TO  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [LAW-1:0]    req_line;
  logic [LW*DW-1:0]  req_wdata, rd_line;
  logic              done, err;
  logic              wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]     wb_adr;
  logic [DW-1:0]     wb_dat_out, wb_dat_in;
  logic [DW/8-1:0]   wb_sel;
  logic              wb_stall, wb_ack, wb_err;

  wb_line_master #(.WB_AW(AW), .WB_DW(DW), .LINE_WORDS(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_line_i(req_line), .req_wdata_i(req_wdata), .rd_line_o(rd_line),
    .done_o(done), .err_o(err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_out), .wb_sel_o(wb_sel),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_dat_in)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { logic [AW-1:0] adr; logic we; logic [DW-1:0] dat; } bus_exp_t;
  typedef struct { logic err; logic [LW*DW-1:0] line; int lat; } done_exp_t;
  typedef struct { logic [DW-1:0] dat; int rdy; } pend_t;

  bus_exp_t   exp_bus[$];
  done_exp_t  exp_done[$];
  pend_t      pend[$];
  logic [DW-1:0] slave_mem [0:4095];
  logic [DW-1:0] ref_mem   [0:4095];
  logic [DW-1:0] exp_rd    [LW];

  int n_checks = 0;
  int n_fail   = 0;
  int accept_cyc = 0;
  int done_seen  = 0;

  // Slave behaviour knobs for the current transfer
  int cfg_lat_max   = 0;
  int cfg_stall_pct = 0;
  int cfg_stall_at  = -1;
  int cfg_stall_len = 0;
  int cfg_err_at    = -1;
  bit cfg_err_ack   = 1'b0;
  bit cfg_no_ack    = 1'b0;

  task automatic check(input string name, input logic [LW*DW-1:0] act, input logic [LW*DW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc_cnt);
    end
  endtask

  // Pipelined slave: responds combinationally-in-cycle from the negedge.
  initial begin : slave
    int str_idx = 0;
    int ack_idx = 0;
    int stalls  = 0;
    bit chk_drop = 1'b0;
    pend_t p;
    bus_exp_t e;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_in = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_in = '0;
        pend.delete(); exp_bus.delete(); chk_drop = 1'b0;
        continue;
      end
      if (chk_drop) begin
        check("cyc_stb_drop_after_err", {wb_cyc, wb_stb}, 2'b00);
        chk_drop = 1'b0;
      end
      if (!wb_cyc) begin
        str_idx = 0; ack_idx = 0; stalls = 0;
      end
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_in = '0;
      if (pend.size() > 0 && pend[0].rdy <= cyc_cnt) begin
        p = pend.pop_front();
        wb_dat_in = p.dat;
        if (ack_idx == cfg_err_at) begin
          wb_err = 1'b1; wb_ack = cfg_err_ack;
          pend.delete(); exp_bus.delete(); chk_drop = 1'b1;
        end else begin
          wb_ack = 1'b1;
        end
        ack_idx++;
      end
      if (wb_err) begin
        wb_stall = 1'b1;
      end else if (wb_stb && str_idx == cfg_stall_at && stalls < cfg_stall_len) begin
        wb_stall = 1'b1; stalls++;
      end else begin
        wb_stall = (int'($urandom_range(99)) < cfg_stall_pct);
      end
      if (wb_stb && !wb_err) begin
        if (exp_bus.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_strobe: adr %h with no strobe expected", wb_adr);
        end else begin
          // The head entry is only retired on acceptance, so a stalled strobe must hold it.
          check("sel", wb_sel, 4'hF);
          check("adr", wb_adr, exp_bus[0].adr);
          check("we", wb_we, exp_bus[0].we);
          if (exp_bus[0].we) check("wdat", wb_dat_out, exp_bus[0].dat);
          if (!wb_stall) begin
            e = exp_bus.pop_front();
            if (wb_we) slave_mem[wb_adr] = wb_dat_out;
            p.dat = slave_mem[wb_adr];
            p.rdy = cyc_cnt + 1 + int'($urandom_range(cfg_lat_max));
            if (!cfg_no_ack) pend.push_back(p);
            str_idx++;
          end
        end
      end
    end
  end

  // Completion monitor
  initial begin : monitor
    done_exp_t d;
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) check("ready_after_done", req_ready, 1'b1);
      prev_done = done;
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: err %b line %h", err, rd_line);
        end else begin
          d = exp_done.pop_front();
          check("err", err, d.err);
          check("rd_line", rd_line, d.line);
          if (d.lat >= 0) check("latency", cyc_cnt - accept_cyc, d.lat);
          if (!d.err) check("strobes_outstanding", exp_bus.size(), 0);
        end
      end
    end
  end

  // Reference model: whole-line semantics against a word-addressed memory image.
  task automatic issue(input bit we, input logic [LAW-1:0] line, input logic [LW*DW-1:0] wd,
                       input int lat, input bit push_exp);
    bus_exp_t  b;
    done_exp_t d;
    int        nrx;
    int        w;
    for (int k = 0; k < LW; k++) begin
      b.adr = {line, IW'(k)}; b.we = we; b.dat = wd[k*DW +: DW];
      exp_bus.push_back(b);
    end
    if (we) begin
      for (int k = 0; k < LW; k++) ref_mem[{line, IW'(k)}] = wd[k*DW +: DW];
    end else begin
      nrx = (cfg_err_at >= 0) ? cfg_err_at : LW;
      for (int k = 0; k < nrx; k++) exp_rd[k] = ref_mem[{line, IW'(k)}];
    end
    d.err = (cfg_err_at >= 0);
    for (int k = 0; k < LW; k++) d.line[k*DW +: DW] = exp_rd[k];
    d.lat = lat;
    if (push_exp) exp_done.push_back(d);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check("req_ready_before_issue", req_ready, 1'b1);
    accept_cyc = cyc_cnt;
    req_valid = 1'b1; req_we = we; req_line = line; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_done.delete();
    foreach (exp_rd[k]) exp_rd[k] = '0;
  endtask

  task automatic wait_done(input int limit);
    int start = done_seen;
    int i = 0;
    while (done_seen == start && i < limit) begin @(negedge clk); i++; end
    if (done_seen == start) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no done_o within %0d cycles", limit);
      pulse_reset();
    end
    @(negedge clk);
  endtask

  task automatic cfg_default();
    cfg_lat_max = 0; cfg_stall_pct = 0; cfg_stall_at = -1; cfg_stall_len = 0;
    cfg_err_at = -1; cfg_err_ack = 1'b0; cfg_no_ack = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    logic [LAW-1:0]   ln;
    logic [LW*DW-1:0] wd;
    logic [LW*DW-1:0] lit;
    int               start;
    bit               we;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_line = '0; req_wdata = '0;
    cfg_default();
    foreach (exp_rd[k]) exp_rd[k] = '0;
    for (int a = 0; a < 4096; a++) begin
      slave_mem[a] = $urandom; ref_mem[a] = slave_mem[a];
    end
    for (int k = 0; k < LW; k++) begin
      slave_mem[12'h014 + k] = 32'hA000_0000 + k; ref_mem[12'h014 + k] = 32'hA000_0000 + k;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_bus", {wb_cyc, wb_stb, wb_we, wb_sel, done, err}, '0);
    check("rst_adr_dat", {wb_adr, wb_dat_out}, '0);
    check("rst_rd_line", rd_line, '0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // Refill of line 0x005 from a zero-stall slave
    issue(1'b0, 10'h005, '0, LW + 2, 1'b1);
    wait_done(50);
    lit = 128'hA0000003_A0000002_A0000001_A0000000;
    check("refill_005", rd_line, lit);

    // Writeback then refill of line 0x3FF
    wd = 128'h44444444_33333333_22222222_11111111;
    issue(1'b1, 10'h3FF, wd, LW + 2, 1'b1);
    wait_done(50);
    for (int k = 0; k < LW; k++) check("wb_mem_word", slave_mem[12'hFFC + k], wd[k*DW +: DW]);
    issue(1'b0, 10'h3FF, '0, LW + 2, 1'b1);
    wait_done(50);
    check("refill_3ff", rd_line, wd);

    // Three stall cycles on the second strobe
    cfg_stall_at = 1; cfg_stall_len = 3;
    issue(1'b0, 10'h123, '0, LW + 5, 1'b1);
    wait_done(50);
    cfg_default();

    // Bus error on the second ack, then error together with the last ack
    cfg_err_at = 1;
    issue(1'b0, 10'h0AA, '0, 4, 1'b1);
    wait_done(50);
    cfg_err_at = LW - 1; cfg_err_ack = 1'b1;
    issue(1'b0, 10'h0BB, '0, LW + 2, 1'b1);
    wait_done(50);
    cfg_default();

    // Reset in the middle of a refill
    cfg_lat_max = 3;
    start = done_seen;
    issue(1'b0, 10'h200, '0, -1, 1'b0);
    @(negedge clk);
    check("cyc_before_rst", wb_cyc, 1'b1);
    rst = 1'b1;
    #1;
    check("cyc_stb_async_rst", {wb_cyc, wb_stb, req_ready}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    exp_done.delete();
    foreach (exp_rd[k]) exp_rd[k] = '0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_seen - start, 0);
    check("rd_line_cleared", rd_line, '0);
    cfg_default();
    issue(1'b0, 10'h201, '0, LW + 2, 1'b1);
    wait_done(50);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      cfg_default();
      cfg_lat_max   = int'($urandom_range(2));
      cfg_stall_pct = int'($urandom_range(40));
      we = 1'(($urandom) & 1);
      ln = LAW'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      if (!we && $urandom_range(4) == 0) begin
        cfg_err_at  = int'($urandom_range(LW - 1));
        cfg_err_ack = 1'($urandom & 1);
      end
      issue(we, ln, wd, -1, 1'b1);
      wait_done(200);
    end

    // Slave that never acknowledges
    cfg_default();
    cfg_no_ack = 1'b1;
`ifdef WB_LINE_TIMEOUT_EN
    cfg_err_at = 0;   // model: aborted with no word received
    issue(1'b0, 10'h300, '0, TO + 2, 1'b1);
    wait_done(60);
`else
    start = done_seen;
    issue(1'b0, 10'h300, '0, -1, 1'b0);
    repeat (100) @(negedge clk);
    check("no_done_without_ack", done_seen - start, 0);
    check("cyc_held_without_ack", wb_cyc, 1'b1);
    pulse_reset();
    @(negedge clk);
`endif
    cfg_default();
    issue(1'b0, 10'h005, '0, LW + 2, 1'b1);
    wait_done(50);
    check("final_queue_empty", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
